timer_controller: RTL and testbench

Sequencing controller for the appliance timer: consumes the five one-cycle debounced button-rise pulses and drives a countdown timer with door interlock, pause/cancel and a completion alarm. It sits between the button edge-detect stage and the display/actuator logic. All outputs are registered.

---
 rtl/timer_controller.sv | 254 +++++++++++++++++++++++++
 tb/tb_timer_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_controller.sv
// rtl/timer_controller.sv - appliance countdown timer sequencing controller
//
// Purpose:
//   Turns the five debounced button-rise pulses into a countdown timer with
//   set/run/pause/done sequencing, a door status bit and a completion alarm.
//   Every output is a flop; a pulse sampled on edge n shows on the outputs
//   after edge n.
//
// Ports:
//   clk         in   1   system clock
//   reset       in   1   asynchronous, active-high reset
//   btn_pulse   in   5   one-cycle rise pulses:
//                        [0]=U up, [1]=C door toggle, [2]=L start,
//                        [3]=R cancel/stop, [4]=D down
//   state       out  3   IDLE=0, SET=1, RUN=2, PAUSE=3, DONE=4
//   remain_sec  out  13  seconds remaining
//   door_open   out  1   door status
//   running     out  1   high in RUN
//   alarm       out  1   high in DONE
//
// Parameters:
//   TICK_DIV   clk cycles per one-second tick
//   STEP_SEC   seconds added/removed per U/D press
//   MAX_SEC    saturation limit for remain_sec
//   ALARM_SEC  ticks the alarm stays on in DONE
//
// Build option:
//   TIMER_DOOR_INTERLOCK_EN - when defined, an open door blocks L and opening
//   the door while running pauses the timer. When undefined the door bit is
//   only toggled and reported.

module timer_controller #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int STEP_SEC  = 10,
  parameter int MAX_SEC   = 5999,
  parameter int ALARM_SEC = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  btn_pulse,
  output logic [2:0]  state,
  output logic [12:0] remain_sec,
  output logic        door_open,
  output logic        running,
  output logic        alarm
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SET   = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);
  localparam logic [13:0]   STEP_W     = 14'(STEP_SEC);
  localparam logic [13:0]   MAX_W      = 14'(MAX_SEC);

  // Architectural state
  logic [2:0]    r_state;
  logic [12:0]   r_remain;
  logic          r_door;
  logic          r_running;
  logic          r_alarm;
  logic [TW-1:0] r_tick_cnt;
  logic [AW-1:0] r_alarm_cnt;

  // Decoded buttons after priority resolution R > C > L > U > D
  logic w_eff_r;
  logic w_eff_c;
  logic w_eff_l;
  logic w_eff_u;
  logic w_eff_d;

  logic          w_tick;
  logic          w_start_ok;
  logic          w_door_pause;
  logic [13:0]   w_run_base;
  logic [13:0]   w_sub;
  logic          w_sub_zero;
  logic [2:0]    w_state_nxt;
  logic [12:0]   w_remain_nxt;
  logic [TW-1:0] w_tick_cnt_nxt;
  logic [AW-1:0] w_alarm_cnt_nxt;

  // Additions are done at 14 bits so a sum past 8191 cannot wrap before
  // the saturation compare.
  function automatic logic [12:0] sat_add(input logic [13:0] base);
    logic [13:0] sum;
    sum = base + STEP_W;
    if (sum > MAX_W) begin
      sat_add = MAX_W[12:0];
    end else begin
      sat_add = sum[12:0];
    end
  endfunction

  assign w_eff_r = btn_pulse[3];
  assign w_eff_c = btn_pulse[1] & ~btn_pulse[3];
  assign w_eff_l = btn_pulse[2] & ~btn_pulse[3] & ~btn_pulse[1];
  assign w_eff_u = btn_pulse[0] & ~btn_pulse[3] & ~btn_pulse[1] & ~btn_pulse[2];
  assign w_eff_d = btn_pulse[4] & ~btn_pulse[3] & ~btn_pulse[1] & ~btn_pulse[2]
                 & ~btn_pulse[0];

  // The tick counter only advances in RUN and DONE, so gating on state keeps
  // a stale count from ever firing elsewhere.
  assign w_tick = ((r_state == ST_RUN) || (r_state == ST_DONE))
                  && (r_tick_cnt == TICK_LAST);

`ifdef TIMER_DOOR_INTERLOCK_EN
  // Door is sampled before this cycle's toggle; a simultaneous C already
  // masks L through the priority decode.
  assign w_start_ok   = ~r_door;
  assign w_door_pause = w_eff_c & ~r_door;
`else
  assign w_start_ok   = 1'b1;
  assign w_door_pause = 1'b0;
`endif

  // In RUN the tick decrement is folded in first so that U on the tick
  // that would reach zero lands exactly on STEP_SEC. RUN is never entered
  // with remain 0, so this cannot underflow.
  assign w_run_base = {1'b0, r_remain} - {13'b0, w_tick};

  // Borrow out of bit 13 flags an underflow; it floors to zero.
  assign w_sub      = {1'b0, r_remain} - STEP_W;
  assign w_sub_zero = w_sub[13] || (w_sub == 14'd0);

  always_comb begin
    w_state_nxt  = r_state;
    w_remain_nxt = r_remain;

    case (r_state)
      ST_IDLE: begin
        w_remain_nxt = 13'd0;
        if (w_eff_u) begin
          w_state_nxt  = ST_SET;
          w_remain_nxt = STEP_W[12:0];
        end
      end

      ST_SET: begin
        if (w_eff_r) begin
          w_state_nxt  = ST_IDLE;
          w_remain_nxt = 13'd0;
        end else if (w_eff_l && w_start_ok) begin
          w_state_nxt = ST_RUN;
        end else if (w_eff_u) begin
          w_remain_nxt = sat_add({1'b0, r_remain});
        end else if (w_eff_d) begin
          if (w_sub_zero) begin
            w_state_nxt  = ST_IDLE;
            w_remain_nxt = 13'd0;
          end else begin
            w_remain_nxt = w_sub[12:0];
          end
        end
      end

      ST_RUN: begin
        // Stopping wins over a coincident tick: remain is left untouched.
        if (w_eff_r || w_door_pause) begin
          w_state_nxt = ST_PAUSE;
        end else if (w_eff_u) begin
          w_remain_nxt = sat_add(w_run_base);
        end else if (w_tick) begin
          w_remain_nxt = w_run_base[12:0];
          if (w_run_base == 14'd0) begin
            w_state_nxt = ST_DONE;
          end
        end
      end

      ST_PAUSE: begin
        if (w_eff_r) begin
          w_state_nxt  = ST_IDLE;
          w_remain_nxt = 13'd0;
        end else if (w_eff_l && w_start_ok) begin
          w_state_nxt = ST_RUN;
        end
      end

      ST_DONE: begin
        w_remain_nxt = 13'd0;
        if (|btn_pulse) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick && (r_alarm_cnt == ALARM_LAST)) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt  = ST_IDLE;
        w_remain_nxt = 13'd0;
      end
    endcase
  end

  // Counters restart from zero on every entry to RUN/DONE (including a
  // resume from PAUSE, which throws away the partial second) and sit at
  // zero in every other state.
  always_comb begin
    w_tick_cnt_nxt  = '0;
    w_alarm_cnt_nxt = '0;

    if (((w_state_nxt == ST_RUN) || (w_state_nxt == ST_DONE))
        && (w_state_nxt == r_state)) begin
      if (w_tick) begin
        w_tick_cnt_nxt = '0;
      end else begin
        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
      end
    end

    if ((w_state_nxt == ST_DONE) && (r_state == ST_DONE)) begin
      if (w_tick) begin
        w_alarm_cnt_nxt = r_alarm_cnt + 1'b1;
      end else begin
        w_alarm_cnt_nxt = r_alarm_cnt;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_remain    <= 13'd0;
      r_door      <= 1'b0;
      r_running   <= 1'b0;
      r_alarm     <= 1'b0;
      r_tick_cnt  <= '0;
      r_alarm_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remain    <= w_remain_nxt;
      // C flips the door in every state, whatever else was pressed.
      r_door      <= r_door ^ btn_pulse[1];
      r_running   <= (w_state_nxt == ST_RUN);
      r_alarm     <= (w_state_nxt == ST_DONE);
      r_tick_cnt  <= w_tick_cnt_nxt;
      r_alarm_cnt <= w_alarm_cnt_nxt;
    end
  end

  assign state      = r_state;
  assign remain_sec = r_remain;
  assign door_open  = r_door;
  assign running    = r_running;
  assign alarm      = r_alarm;

endmodule

// File: tb/tb_timer_controller.sv
// tb/tb_timer_controller.sv - directed self-checking bench for timer_controller

module tb_timer_controller;

  localparam logic [4:0] B_U = 5'b00001;
  localparam logic [4:0] B_C = 5'b00010;
  localparam logic [4:0] B_L = 5'b00100;
  localparam logic [4:0] B_R = 5'b01000;
  localparam logic [4:0] B_D = 5'b10000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  btn_pulse = 5'b0;
  logic [2:0]  state;
  logic [12:0] remain_sec;
  logic        door_open;
  logic        running;
  logic        alarm;

  int total = 0;
  int passed = 0;

  timer_controller #(
    .TICK_DIV (4),
    .STEP_SEC (10),
    .MAX_SEC  (5999),
    .ALARM_SEC(5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_pulse (btn_pulse),
    .state     (state),
    .remain_sec(remain_sec),
    .door_open (door_open),
    .running   (running),
    .alarm     (alarm)
  );

  always #5 clk = ~clk;

  // All tasks start and end on a falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse is sampled on the next rising edge; returns on the falling edge after it.
  task automatic pulse(input logic [4:0] b);
    btn_pulse = b;
    @(negedge clk);
    btn_pulse = 5'b0;
  endtask

  task automatic test_reset;
    step(2);
    total++; if ({state, remain_sec, door_open, running, alarm} !== 19'd0) $display("FAIL reset_held got=%h exp=0", {state, remain_sec, door_open, running, alarm}); else passed++;
    reset = 1'b0;
    step(2);
    total++; if ({state, remain_sec, door_open, running, alarm} !== 19'd0) $display("FAIL reset_released got=%h exp=0", {state, remain_sec, door_open, running, alarm}); else passed++;
  endtask

  task automatic test_set;
    pulse(B_U);
    total++; if (state !== 3'd1 || remain_sec !== 13'd10) $display("FAIL set_first_u got=%0d/%0d exp=1/10", state, remain_sec); else passed++;
    pulse(B_U);
    pulse(B_U);
    total++; if (state !== 3'd1 || remain_sec !== 13'd30) $display("FAIL set_three_u got=%0d/%0d exp=1/30", state, remain_sec); else passed++;
    pulse(B_D);
    pulse(B_D);
    total++; if (state !== 3'd1 || remain_sec !== 13'd10) $display("FAIL set_two_d got=%0d/%0d exp=1/10", state, remain_sec); else passed++;
    pulse(B_D);
    total++; if (state !== 3'd0 || remain_sec !== 13'd0) $display("FAIL set_d_to_zero got=%0d/%0d exp=0/0", state, remain_sec); else passed++;
    pulse(B_D);
    total++; if (state !== 3'd0 || remain_sec !== 13'd0) $display("FAIL idle_d got=%0d/%0d exp=0/0", state, remain_sec); else passed++;
  endtask

  task automatic test_run_done;
    pulse(B_U);
    pulse(B_L);
    total++; if (state !== 3'd2 || running !== 1'b1 || remain_sec !== 13'd10) $display("FAIL run_entry got=%0d/%0d/%0d exp=2/1/10", state, running, remain_sec); else passed++;
    step(3);
    total++; if (remain_sec !== 13'd10) $display("FAIL run_before_tick got=%0d exp=10", remain_sec); else passed++;
    step(1);
    total++; if (remain_sec !== 13'd9) $display("FAIL run_first_tick got=%0d exp=9", remain_sec); else passed++;
    step(35);
    total++; if (state !== 3'd2 || remain_sec !== 13'd1) $display("FAIL run_last_second got=%0d/%0d exp=2/1", state, remain_sec); else passed++;
    step(1);
    total++; if (state !== 3'd4 || alarm !== 1'b1 || running !== 1'b0 || remain_sec !== 13'd0) $display("FAIL done_entry got=%0d/%0d/%0d/%0d exp=4/1/0/0", state, alarm, running, remain_sec); else passed++;
    step(19);
    total++; if (state !== 3'd4 || alarm !== 1'b1) $display("FAIL done_hold got=%0d/%0d exp=4/1", state, alarm); else passed++;
    step(1);
    total++; if (state !== 3'd0 || alarm !== 1'b0) $display("FAIL done_timeout got=%0d/%0d exp=0/0", state, alarm); else passed++;
  endtask

  task automatic test_done_pulse;
    pulse(B_U);
    pulse(B_L);
    step(40);
    total++; if (state !== 3'd4) $display("FAIL done_pulse_entry got=%0d exp=4", state); else passed++;
    pulse(B_D);
    total++; if (state !== 3'd0 || alarm !== 1'b0) $display("FAIL done_pulse_exit got=%0d/%0d exp=0/0", state, alarm); else passed++;
  endtask

  task automatic test_door;
    pulse(B_U);
    pulse(B_L);
    step(2);
    pulse(B_C);
`ifdef TIMER_DOOR_INTERLOCK_EN
    total++; if (state !== 3'd3 || door_open !== 1'b1 || running !== 1'b0 || remain_sec !== 13'd10) $display("FAIL door_pause got=%0d/%0d/%0d/%0d exp=3/1/0/10", state, door_open, running, remain_sec); else passed++;
    step(8);
    total++; if (state !== 3'd3 || remain_sec !== 13'd10) $display("FAIL door_frozen got=%0d/%0d exp=3/10", state, remain_sec); else passed++;
    pulse(B_L);
    total++; if (state !== 3'd3) $display("FAIL door_blocks_l got=%0d exp=3", state); else passed++;
    pulse(B_C);
    total++; if (state !== 3'd3 || door_open !== 1'b0) $display("FAIL door_close got=%0d/%0d exp=3/0", state, door_open); else passed++;
    pulse(B_L);
    total++; if (state !== 3'd2 || remain_sec !== 13'd10) $display("FAIL resume got=%0d/%0d exp=2/10", state, remain_sec); else passed++;
    step(3);
    total++; if (remain_sec !== 13'd10) $display("FAIL resume_full_period got=%0d exp=10", remain_sec); else passed++;
    step(1);
    total++; if (remain_sec !== 13'd9) $display("FAIL resume_tick got=%0d exp=9", remain_sec); else passed++;
`else
    total++; if (state !== 3'd2 || door_open !== 1'b1 || running !== 1'b1) $display("FAIL door_no_interlock got=%0d/%0d/%0d exp=2/1/1", state, door_open, running); else passed++;
    step(1);
    total++; if (remain_sec !== 13'd9) $display("FAIL door_tick_kept got=%0d exp=9", remain_sec); else passed++;
    pulse(B_C);
    total++; if (state !== 3'd2 || door_open !== 1'b0) $display("FAIL door_close_run got=%0d/%0d exp=2/0", state, door_open); else passed++;
`endif
    pulse(B_R);
    total++; if (state !== 3'd3 || remain_sec !== 13'd9) $display("FAIL r_pause got=%0d/%0d exp=3/9", state, remain_sec); else passed++;
    pulse(B_R);
    total++; if (state !== 3'd0 || remain_sec !== 13'd0) $display("FAIL r_cancel got=%0d/%0d exp=0/0", state, remain_sec); else passed++;
  endtask

  task automatic test_saturate;
    pulse(B_U);
    repeat (598) pulse(B_U);
    total++; if (remain_sec !== 13'd5990) $display("FAIL sat_reach got=%0d exp=5990", remain_sec); else passed++;
    pulse(B_U);
    total++; if (remain_sec !== 13'd5999) $display("FAIL sat_clip got=%0d exp=5999", remain_sec); else passed++;
    pulse(B_U);
    total++; if (remain_sec !== 13'd5999) $display("FAIL sat_hold got=%0d exp=5999", remain_sec); else passed++;
    pulse(B_R | B_L);
    total++; if (state !== 3'd0 || remain_sec !== 13'd0) $display("FAIL r_plus_l got=%0d/%0d exp=0/0", state, remain_sec); else passed++;
  endtask

  task automatic test_priority;
    pulse(B_U);
    pulse(B_C | B_L);
    total++; if (state !== 3'd1 || door_open !== 1'b1) $display("FAIL c_over_l got=%0d/%0d exp=1/1", state, door_open); else passed++;
    pulse(B_C | B_U);
    total++; if (state !== 3'd1 || door_open !== 1'b0 || remain_sec !== 13'd10) $display("FAIL c_over_u got=%0d/%0d/%0d exp=1/0/10", state, door_open, remain_sec); else passed++;
    pulse(B_U | B_D);
    total++; if (remain_sec !== 13'd20) $display("FAIL u_over_d got=%0d exp=20", remain_sec); else passed++;
    pulse(B_R | B_C);
    total++; if (state !== 3'd0 || door_open !== 1'b1) $display("FAIL r_with_c got=%0d/%0d exp=0/1", state, door_open); else passed++;
    pulse(B_C);
    total++; if (door_open !== 1'b0) $display("FAIL idle_c got=%0d exp=0", door_open); else passed++;
  endtask

  task automatic test_tick_r;
    pulse(B_U);
    pulse(B_L);
    step(3);
    pulse(B_R);
    total++; if (state !== 3'd3 || remain_sec !== 13'd10) $display("FAIL tick_r got=%0d/%0d exp=3/10", state, remain_sec); else passed++;
    pulse(B_R);
  endtask

  task automatic test_tick_u;
    pulse(B_U);
    pulse(B_L);
    step(39);
    total++; if (remain_sec !== 13'd1) $display("FAIL tick_u_pre got=%0d exp=1", remain_sec); else passed++;
    pulse(B_U);
    total++; if (state !== 3'd2 || remain_sec !== 13'd10 || alarm !== 1'b0) $display("FAIL tick_u got=%0d/%0d/%0d exp=2/10/0", state, remain_sec, alarm); else passed++;
    pulse(B_R);
    pulse(B_R);
  endtask

  task automatic test_reset_mid_run;
    pulse(B_U);
    pulse(B_L);
    step(9);
    pulse(B_C);
    total++; if (door_open !== 1'b1 || remain_sec !== 13'd8) $display("FAIL mid_run_pre got=%0d/%0d exp=1/8", door_open, remain_sec); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if ({state, remain_sec, door_open, running, alarm} !== 19'd0) $display("FAIL async_reset got=%h exp=0", {state, remain_sec, door_open, running, alarm}); else passed++;
    @(negedge clk);
    reset = 1'b0;
    step(50);
    total++; if (state !== 3'd0 || alarm !== 1'b0 || remain_sec !== 13'd0) $display("FAIL post_reset got=%0d/%0d/%0d exp=0/0/0", state, alarm, remain_sec); else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_set();
    test_run_done();
    test_done_pulse();
    test_door();
    test_saturate();
    test_priority();
    test_tick_r();
    test_tick_u();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
